// File: rtl/cpu_debug_cmd_arbiter_if.sv
// Debug command stream from the arbiter FIFO head to the instrumentation logic.
// Signals: cmd_valid/cmd_ready handshake, cmd_ch source channel, cmd_ir
// instruction, cmd_jdo data register, cmd_action decoded action flag.
// master = arbiter (drives the head), slave = consumer (drives cmd_ready).
interface cpu_debug_cmd_arbiter_if #(
  parameter int unsigned CH_W = 1,
  parameter int unsigned IR_W = 2,
  parameter int unsigned DR_W = 38
);
  logic            cmd_valid;
  logic            cmd_ready;
  logic [CH_W-1:0] cmd_ch;
  logic [IR_W-1:0] cmd_ir;
  logic [DR_W-1:0] cmd_jdo;
  logic            cmd_action;

  modport master (
    output cmd_valid, cmd_ch, cmd_ir, cmd_jdo, cmd_action,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_ch, cmd_ir, cmd_jdo, cmd_action,
    output cmd_ready
  );
endinterface

// File: rtl/cpu_debug_cmd_arbiter.sv
// System-clock side of the multi-core CPU debug slave: synchronises per-channel
// update toggles, captures IR/DR per channel, arbitrates channels round-robin
// into a command FIFO and presents the head as a valid/ready stream.
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   ch_udr_tgl        per-channel update toggle (tck domain, asynchronous)
//   ch_ir, ch_sr      per-channel instruction / data registers, packed by channel
//   cmd               command stream (master modport)
//   ovf               sticky per-channel overflow flags
//   fifo_level        FIFO occupancy 0..FIFO_DEPTH
module cpu_debug_cmd_arbiter #(
  parameter int unsigned N_CH        = 2,
  parameter int unsigned IR_W        = 2,
  parameter int unsigned DR_W        = 38,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [N_CH-1:0]               ch_udr_tgl,
  input  logic [N_CH*IR_W-1:0]          ch_ir,
  input  logic [N_CH*DR_W-1:0]          ch_sr,
  cpu_debug_cmd_arbiter_if.master       cmd,
  output logic [N_CH-1:0]               ovf,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);
  localparam int unsigned CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam int unsigned GRD_W = $clog2(SYNC_STAGES + 2);

  logic [N_CH-1:0]  sync_q [SYNC_STAGES];
  logic [N_CH-1:0]  dly_q, edge_q, pend_q, pend_d, ovf_q, ovf_d, cap, gnt_mask;
  logic [GRD_W-1:0] grd_q;
  logic [IR_W-1:0]  hold_ir_q [N_CH];
  logic [DR_W-1:0]  hold_sr_q [N_CH];
  logic [CH_W-1:0]  rr_q, rr_d, gnt_ch;
  logic             gnt_vld, pop;
  logic [CH_W-1:0]  mem_ch_q [FIFO_DEPTH];
  logic [IR_W-1:0]  mem_ir_q [FIFO_DEPTH];
  logic [DR_W-1:0]  mem_sr_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr_q, rptr_q;
  logic [LVL_W-1:0] lvl_q, lvl_d;

  // Arbitration, capture/overflow and FIFO level bookkeeping
  always_comb begin
    int unsigned idx;
    idx      = 0;
    gnt_vld  = 1'b0;
    gnt_ch   = '0;
    rr_d     = rr_q;
    gnt_mask = '0;
    // Round-robin search from rr upward; grant only when a slot is free now
    if (lvl_q < LVL_W'(FIFO_DEPTH)) begin
      for (int unsigned k = 0; k < N_CH; k++) begin
        idx = 32'(rr_q) + k;
        if (idx >= N_CH) idx = idx - N_CH;
        if (!gnt_vld && pend_q[idx[CH_W-1:0]]) begin
          gnt_vld = 1'b1;
          gnt_ch  = idx[CH_W-1:0];
        end
      end
    end
    if (gnt_vld) begin
      rr_d = (gnt_ch == CH_W'(N_CH - 1)) ? '0 : gnt_ch + CH_W'(1);
    end
    for (int unsigned i = 0; i < N_CH; i++) begin
      gnt_mask[i] = gnt_vld && (gnt_ch == CH_W'(i));
    end
    // A granted channel frees its holding register in the same cycle
    cap    = edge_q & (~pend_q | gnt_mask);
    pend_d = (pend_q & ~gnt_mask) | cap;
    ovf_d  = ovf_q | (edge_q & pend_q & ~gnt_mask);
    pop    = (lvl_q != '0) && cmd.cmd_ready;
    lvl_d  = lvl_q;
    if (gnt_vld && !pop)      lvl_d = lvl_q + LVL_W'(1);
    else if (!gnt_vld && pop) lvl_d = lvl_q - LVL_W'(1);
  end

  // State registers, synchronisers, holding registers and FIFO storage
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      dly_q  <= '0;
      edge_q <= '0;
      pend_q <= '0;
      ovf_q  <= '0;
      rr_q   <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
      lvl_q  <= '0;
      grd_q  <= GRD_W'(SYNC_STAGES + 1);
      for (int unsigned i = 0; i < N_CH; i++) begin
        hold_ir_q[i] <= '0;
        hold_sr_q[i] <= '0;
      end
      for (int unsigned j = 0; j < FIFO_DEPTH; j++) begin
        mem_ch_q[j] <= '0;
        mem_ir_q[j] <= '0;
        mem_sr_q[j] <= '0;
      end
    end else begin
      sync_q[0] <= ch_udr_tgl;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      dly_q <= sync_q[SYNC_STAGES-1];
      // Edge pulse is registered; masked while the post-reset guard runs
      edge_q <= (sync_q[SYNC_STAGES-1] ^ dly_q) & {N_CH{grd_q == '0}};
      if (grd_q != '0) grd_q <= grd_q - GRD_W'(1);
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
      rr_q   <= rr_d;
      lvl_q  <= lvl_d;
      for (int unsigned i = 0; i < N_CH; i++) begin
        if (cap[i]) begin
          hold_ir_q[i] <= ch_ir[i*IR_W +: IR_W];
          hold_sr_q[i] <= ch_sr[i*DR_W +: DR_W];
        end
      end
      if (gnt_vld) begin
        mem_ch_q[wptr_q] <= gnt_ch;
        mem_ir_q[wptr_q] <= hold_ir_q[gnt_ch];
        mem_sr_q[wptr_q] <= hold_sr_q[gnt_ch];
        wptr_q           <= wptr_q + PTR_W'(1);
      end
      if (pop) rptr_q <= rptr_q + PTR_W'(1);
    end
  end

  // Head presented from registered storage
  assign cmd.cmd_valid  = (lvl_q != '0);
  assign cmd.cmd_ch     = mem_ch_q[rptr_q];
  assign cmd.cmd_ir     = mem_ir_q[rptr_q];
  assign cmd.cmd_jdo    = mem_sr_q[rptr_q];
  assign cmd.cmd_action = mem_sr_q[rptr_q][DR_W-3];
  assign ovf            = ovf_q;
  assign fifo_level     = lvl_q;
endmodule

// File: tb/tb_cpu_debug_cmd_arbiter.sv
// Directed bench for cpu_debug_cmd_arbiter with default parameters.
module tb_cpu_debug_cmd_arbiter;
  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  tgl;
  logic [3:0]  ir_bus;
  logic [75:0] sr_bus;
  logic [1:0]  ovf;
  logic [2:0]  lvl;

  always #5 clk = ~clk;

  cpu_debug_cmd_arbiter_if #(.CH_W(1), .IR_W(2), .DR_W(38)) cmd_if ();

  cpu_debug_cmd_arbiter dut (
    .clk        (clk),
    .reset      (reset),
    .ch_udr_tgl (tgl),
    .ch_ir      (ir_bus),
    .ch_sr      (sr_bus),
    .cmd        (cmd_if),
    .ovf        (ovf),
    .fifo_level (lvl)
  );

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          ch;
    logic [1:0]  ir;
    logic [37:0] sr;
    logic        act;
  } vec_t;

  vec_t        vecs [4];
  logic [37:0] bp   [5];
  logic [37:0] fill [4];
  logic [37:0] xval;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input int c, input logic [1:0] ir, input logic [37:0] sr);
    ir_bus[c*2 +: 2]  = ir;
    sr_bus[c*38 +: 38] = sr;
    tgl[c] = ~tgl[c];
  endtask

  initial begin
    vecs[0] = '{ch: 0, ir: 2'b00, sr: 38'h08_1234_5678, act: 1'b1};
    vecs[1] = '{ch: 1, ir: 2'b11, sr: 38'h37_0000_0001, act: 1'b0};
    vecs[2] = '{ch: 1, ir: 2'b01, sr: 38'h00_0000_0000, act: 1'b0};
    vecs[3] = '{ch: 0, ir: 2'b10, sr: 38'h08_0000_0000, act: 1'b1};
    bp[0] = 38'h01_1111_1111; bp[1] = 38'h02_2222_2222; bp[2] = 38'h03_3333_3333;
    bp[3] = 38'h04_4444_4444; bp[4] = 38'h05_5555_5555;
    fill[0] = 38'h10_0000_00A0; fill[1] = 38'h10_0000_00A1;
    fill[2] = 38'h10_0000_00A2; fill[3] = 38'h10_0000_00A3;
    xval = 38'h2A_AAAA_5555;

    reset = 1'b1; tgl = '0; ir_bus = '0; sr_bus = '0; cmd_if.cmd_ready = 1'b0;
    tick(3);
    chk("rst_valid", cmd_if.cmd_valid, 0);
    chk("rst_level", lvl, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_ch", cmd_if.cmd_ch, 0);
    chk("rst_ir", cmd_if.cmd_ir, 0);
    chk("rst_jdo", cmd_if.cmd_jdo, 0);
    chk("rst_action", cmd_if.cmd_action, 0);
    reset = 1'b0;
    tick(6);

    // Single commands with cmd_ready high: valid appears after edge 5
    cmd_if.cmd_ready = 1'b1;
    for (int v = 0; v < 4; v++) begin
      send(vecs[v].ch, vecs[v].ir, vecs[v].sr);
      tick(4);
      chk("lat_early", cmd_if.cmd_valid, 0);
      tick(1);
      chk("vec_valid", cmd_if.cmd_valid, 1);
      chk("vec_ch", cmd_if.cmd_ch, 64'(vecs[v].ch));
      chk("vec_ir", cmd_if.cmd_ir, vecs[v].ir);
      chk("vec_jdo", cmd_if.cmd_jdo, vecs[v].sr);
      chk("vec_action", cmd_if.cmd_action, vecs[v].act);
      chk("vec_level", lvl, 1);
      tick(1);
      chk("vec_drain", cmd_if.cmd_valid, 0);
      chk("vec_level0", lvl, 0);
      tick(2);
    end

    // Fairness with rr=1 (last grant was ch0): ch1 then ch0
    send(0, 2'b00, 38'h00_0000_0A01);
    send(1, 2'b00, 38'h00_0000_0B01);
    tick(5);
    chk("fair1_first", cmd_if.cmd_ch, 1);
    chk("fair1_first_jdo", cmd_if.cmd_jdo, 38'h00_0000_0B01);
    tick(1);
    chk("fair1_second", cmd_if.cmd_ch, 0);
    chk("fair1_second_jdo", cmd_if.cmd_jdo, 38'h00_0000_0A01);
    tick(1);
    chk("fair1_empty", cmd_if.cmd_valid, 0);
    // One ch1 command moves rr to 0
    send(1, 2'b01, 38'h00_0000_0C01);
    tick(5);
    chk("fair_prep_ch", cmd_if.cmd_ch, 1);
    tick(3);
    send(0, 2'b00, 38'h00_0000_0A02);
    send(1, 2'b00, 38'h00_0000_0B02);
    tick(5);
    chk("fair0_first", cmd_if.cmd_ch, 0);
    tick(1);
    chk("fair0_second", cmd_if.cmd_ch, 1);
    tick(1);
    chk("fair0_empty", cmd_if.cmd_valid, 0);
    chk("fair_ovf", ovf, 0);
    tick(2);

    // Backpressure: four fill the FIFO, fifth waits in pend
    cmd_if.cmd_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      send(k % 2, 2'(k), bp[k]);
      tick(6);
    end
    tick(4);
    chk("bp_level_full", lvl, 4);
    chk("bp_valid", cmd_if.cmd_valid, 1);
    cmd_if.cmd_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("bp_order_jdo", cmd_if.cmd_jdo, bp[k]);
      chk("bp_order_ch", cmd_if.cmd_ch, 64'(k % 2));
      tick(1);
    end
    chk("bp_empty", cmd_if.cmd_valid, 0);
    chk("bp_level0", lvl, 0);
    chk("bp_ovf", ovf, 0);
    tick(2);

    // Overflow: FIFO full of ch1 entries, ch0 pending, second ch0 update dropped
    cmd_if.cmd_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      send(1, 2'b00, fill[k]);
      tick(6);
    end
    send(0, 2'b10, xval);
    tick(8);
    chk("ovf_before", ovf, 0);
    chk("ovf_full", lvl, 4);
    send(0, 2'b11, 38'h1);
    tick(8);
    chk("ovf_set", ovf, 2'b01);
    cmd_if.cmd_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("ovf_pop_jdo", cmd_if.cmd_jdo, (k < 4) ? fill[k] : xval);
      tick(1);
    end
    chk("ovf_empty", cmd_if.cmd_valid, 0);
    tick(10);
    chk("ovf_no_new", cmd_if.cmd_valid, 0);
    chk("ovf_sticky", ovf, 2'b01);

    // Reset with three queued commands
    cmd_if.cmd_ready = 1'b0;
    send(0, 2'b00, 38'h00_0000_0D01); tick(6);
    send(1, 2'b00, 38'h00_0000_0D02); tick(6);
    send(0, 2'b00, 38'h00_0000_0D03); tick(8);
    chk("mid_level3", lvl, 3);
    reset = 1'b1;
    tick(1);
    chk("mid_rst_level", lvl, 0);
    chk("mid_rst_valid", cmd_if.cmd_valid, 0);
    chk("mid_rst_ovf", ovf, 0);
    reset = 1'b0;
    tick(10);
    chk("mid_rst_quiet", cmd_if.cmd_valid, 0);

    // Toggles held high through reset are not reported
    reset = 1'b1;
    tgl   = 2'b11;
    tick(2);
    reset = 1'b0;
    cmd_if.cmd_ready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      chk("guard_quiet", cmd_if.cmd_valid, 0);
    end
    send(0, 2'b01, 38'h08_0000_0001);
    tick(5);
    chk("post_guard_valid", cmd_if.cmd_valid, 1);
    chk("post_guard_jdo", cmd_if.cmd_jdo, 38'h08_0000_0001);
    tick(1);
    chk("post_guard_drain", cmd_if.cmd_valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/cpu_debug_cmd_arbiter.md
# cpu_debug_cmd_arbiter

Parametrised system-clock side of the CPU debug slave. It accepts debug-register updates from `N_CH` JTAG debug channels, one per CPU core. Each channel delivers a toggle strobe from the `tck` domain plus a held instruction and data register. The block synchronises the strobes, captures each update and arbitrates the channels round-robin into a command FIFO. It presents one valid/ready command stream, with a decoded action flag, to the on-chip-instrumentation logic. It replaces the single-channel, pulse-only sysclk decoder and adds multi-core support, buffering, backpressure and overflow reporting.

## Interface
Parameters:
- `N_CH`, 2: number of debug channels, 1..8.
- `IR_W`, 2: instruction register width.
- `DR_W`, 38: data (shift) register width, at least 4.
- `SYNC_STAGES`, 2: synchroniser flops per strobe, 2..4.
- `FIFO_DEPTH`, 4: command FIFO entries, a power of 2 from 2 to 16.
- Local parameters: `CH_W = max(1, clog2(N_CH))` and `LVL_W = clog2(FIFO_DEPTH)+1`.

Ports:
- `clk` in 1: system clock.
- `reset` in 1: synchronous, active-high reset.
- `ch_udr_tgl` in `N_CH`: per-channel update toggle from the `tck` domain. Asynchronous to `clk`. Bit i flips once per update of channel i.
- `ch_ir` in `N_CH*IR_W`: per-channel instruction register. Channel i occupies `[i*IR_W +: IR_W]`. Stable for at least `SYNC_STAGES+2` clk cycles after its toggle.
- `ch_sr` in `N_CH*DR_W`: per-channel data register. Same packing and stability rule as `ch_ir`.
- `cmd_valid` out 1: FIFO head is valid.
- `cmd_ready` in 1: consumer accepts the head.
- `cmd_ch` out `CH_W`: source channel of the head entry.
- `cmd_ir` out `IR_W`: instruction register of the head entry.
- `cmd_jdo` out `DR_W`: data register of the head entry.
- `cmd_action` out 1: action flag of the head entry, equal to `cmd_jdo[DR_W-3]`.
- `ovf` out `N_CH`: sticky per-channel overflow flag.
- `fifo_level` out `LVL_W`: current FIFO occupancy, 0..`FIFO_DEPTH`.

## Operation
- **Synchroniser, per channel.**
  - `SYNC_STAGES` flops carry `ch_udr_tgl[i]`, followed by one delay flop `d_i`.
  - The edge signal `e_i` is high when the last sync stage differs from `d_i`.
- **Post-reset guard.**
  - A counter is loaded with `SYNC_STAGES+1` during reset and decrements to 0 afterwards.
  - `e_i` is ignored while the counter is non-zero.
  - The sync and delay flops keep clocking while the counter runs, so a toggle input held at 1 through reset produces no command.
- **Capture.** On `e_i`, `ch_ir[i]` and `ch_sr[i]` are registered into holding register i and `pend[i]` is set.
- **Overflow.**
  - If `e_i` arrives while `pend[i]=1` and channel i is not granted in that cycle, the new update is dropped, the old data is kept and `ovf[i]` is set.
  - `ovf[i]` is cleared only by reset.
- **Arbiter.**
  - Round-robin with pointer `rr`. The grant goes to the first channel with `pend=1`, searching from `rr` upward and wrapping at `N_CH-1`.
  - A grant is issued only when `fifo_level < FIFO_DEPTH`. A pop in the same cycle does not free a slot for a push in that cycle.
  - A grant pushes `{ch, ir, sr}` into the FIFO, clears `pend[g]` and sets `rr = g+1 mod N_CH`.
  - With no grant, `rr` holds.
- **Grant and capture together.** Capture and grant of the same channel in the same cycle means the old data is pushed, the new data is captured and `pend` stays 1. No overflow is flagged.
- **FIFO.**
  - The head is presented combinationally from registered storage.
  - A pop happens when `cmd_valid && cmd_ready`. `cmd_ready` while empty is ignored.
  - Push and pop in the same cycle leave the level unchanged. Read and write pointers wrap at `FIFO_DEPTH`.
- **Head outputs.** `cmd_valid = (fifo_level != 0)`. `cmd_ch`, `cmd_ir`, `cmd_jdo` and `cmd_action` are don't-care while `cmd_valid=0`.
- **Reset.**
  - Clears sync stages, delay flops, `pend`, `ovf`, `rr`, FIFO pointers and level, and holding and storage registers.
  - Reset values: `cmd_valid=0`, `fifo_level=0`, `ovf=0`, `cmd_ch=0`, `cmd_ir=0`, `cmd_jdo=0`, `cmd_action=0`.
  - Reset asserted mid-operation discards all pending and queued commands in the next cycle.

## Timing
- All state changes on the rising edge of `clk`.
- **Latency.** A toggle that is stable before edge 1 produces:
  - the capture at edge `SYNC_STAGES+2`;
  - the FIFO push at edge `SYNC_STAGES+3`;
  - `cmd_valid=1` after that edge.
  - With defaults, this is `cmd_valid` after edge 5.
- **Throughput.** One push per cycle and one pop per cycle sustained. For a single channel, back-to-back updates need 2 or more cycles between `e_i` pulses to avoid overflow.
- **Guard.** Toggles during the first `SYNC_STAGES+1` cycles after reset deasserts are not reported.
- **Grant timing.** The grant decision uses registered `pend` and `fifo_level`. There is no combinational path from `cmd_ready` to the grant.
- **Output path.** `cmd_valid` depends only on registered state. There is no combinational path from `cmd_ready` to `cmd_valid`.

## Test plan
1. **Single command.** Defaults, `cmd_ready=1`, toggle ch0 with `ir=2'b00`, `sr=38'h08_1234_5678` (bit 35 = 1). Expect `cmd_valid` after edge 5 for one cycle with `cmd_ch=0`, `cmd_action=1`, `fifo_level` returning to 0.
2. **Fairness.** Toggle ch0 and ch1 in the same cycle with `rr=0`. Expect pops in order ch0 then ch1. Repeat with `rr=1`: expect ch1 then ch0. `ovf=0` throughout.
3. **Backpressure and full.** `cmd_ready=0`, 5 spaced updates alternating between ch0 and ch1. Expect `fifo_level=4` and the fifth held in `pend`. Raise `cmd_ready`: expect all 5 popped in arrival order with no `ovf`.
4. **Overflow.** FIFO full and ch0 pending, then toggle ch0 again with `sr=38'h1`. Expect `ovf[0]=1` and the old data later popped. `sr=38'h1` is never seen.
5. **Reset guard.** Hold `ch_udr_tgl=2'b11` through reset. Expect no `cmd_valid` for 20 cycles after release.
6. **Reset mid-operation.** Assert reset for 1 cycle with `fifo_level=3`. Expect `fifo_level=0`, `cmd_valid=0` and `ovf=0` after that edge.
